// File: rtl/pe_mac_param.sv
// Systolic-array processing element: operand FIFOs feeding a signed MAC, with
// east/south operand forwarding and a re-timed start for chaining neighbours.

module pe_mac_fifo #(
  parameter int DW     = 16,
  parameter int FDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_drop
);
  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

  logic [DW-1:0] r_mem [FDEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;
  logic          w_wr;

  assign o_full  = (r_cnt == (PW+1)'(FDEPTH));
  assign o_empty = (r_cnt == '0);
  // A pop in the same cycle frees a slot, so a write into a full FIFO is legal then.
  assign w_wr    = i_we && (!o_full || i_pop);
  assign o_drop  = i_we && o_full && !i_pop;
  assign o_rdata = r_mem[r_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
      case ({w_wr, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end
endmodule

module pe_mac_param #(
  parameter int DW     = 16,
  parameter int ACC_W  = 40,
  parameter int FDEPTH = 4,
  parameter int CNT_W  = 8,
  parameter int FRAC   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] max_cntr,
  input  logic             mode_sat,
  input  logic [DW-1:0]    a_in,
  input  logic             awe,
  input  logic [DW-1:0]    b_in,
  input  logic             bwe,
  output logic             aff,
  output logic             bff,
  output logic             aerr,
  output logic             berr,
  output logic [DW-1:0]    a_out,
  output logic             a_ov,
  output logic [DW-1:0]    b_out,
  output logic             b_ov,
  output logic             start_next,
  output logic             busy,
  output logic [DW-1:0]    s_out,
  output logic             se,
  output logic             sat
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic signed [ACC_W-1:0] L_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] L_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t                   r_state, w_state_nxt;
  logic                     w_accept;
  logic                     w_pop;
  logic [DW-1:0]            w_ard, w_brd;
  logic                     w_aempty, w_bempty, w_adrop, w_bdrop;
  logic signed [DW-1:0]     w_a, w_b;
  logic signed [2*DW-1:0]   w_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_mode;
  logic                     r_aerr, r_berr;
  logic [DW-1:0]            r_a_out, r_b_out, r_s_out;
  logic                     r_a_ov, r_b_ov, r_start_next, r_se, r_sat;
  logic [DW:0]              w_result;

  // Floor-shift the accumulator, then clamp (mode 1) or truncate (mode 0).
  // Returns {clamped, value}.
  function automatic logic [DW:0] f_round_sat(input logic signed [ACC_W-1:0] acc,
                                              input logic ms);
    logic signed [ACC_W-1:0] r;
    r = acc >>> FRAC;
    if (ms && (r > L_MAX))      return {1'b1, L_MAX[DW-1:0]};
    else if (ms && (r < L_MIN)) return {1'b1, L_MIN[DW-1:0]};
    else                        return {1'b0, r[DW-1:0]};
  endfunction

  pe_mac_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_afifo (
    .clk(clk), .rst_n(rst_n), .i_we(awe), .i_pop(w_pop), .i_wdata(a_in),
    .o_rdata(w_ard), .o_full(aff), .o_empty(w_aempty), .o_drop(w_adrop)
  );

  pe_mac_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_bfifo (
    .clk(clk), .rst_n(rst_n), .i_we(bwe), .i_pop(w_pop), .i_wdata(b_in),
    .o_rdata(w_brd), .o_full(bff), .o_empty(w_bempty), .o_drop(w_bdrop)
  );

  assign w_pop    = (r_state == RUN) && !w_aempty && !w_bempty;
  assign w_a      = w_ard;
  assign w_b      = w_brd;
  assign w_prod   = w_a * w_b;
  assign w_result = f_round_sat(r_acc, r_mode);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_accept    = 1'b1;
        w_state_nxt = (max_cntr == '0) ? DONE : RUN;
      end
      RUN:  if (w_pop && (r_cnt == CNT_W'(1))) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_mode       <= 1'b0;
      r_aerr       <= 1'b0;
      r_berr       <= 1'b0;
      r_a_out      <= '0;
      r_b_out      <= '0;
      r_a_ov       <= 1'b0;
      r_b_ov       <= 1'b0;
      r_start_next <= 1'b0;
      r_s_out      <= '0;
      r_se         <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_next <= w_accept;
      r_a_ov       <= w_pop;
      r_b_ov       <= w_pop;
      r_aerr       <= (r_aerr && !w_accept) || w_adrop;
      r_berr       <= (r_berr && !w_accept) || w_bdrop;
      r_se         <= (r_state == DONE);
      if (w_pop) begin
        r_a_out <= w_ard;
        r_b_out <= w_brd;
        r_acc   <= r_acc + ACC_W'(w_prod);
        r_cnt   <= r_cnt - 1'b1;
      end
      if (w_accept) begin
        r_acc  <= '0;
        r_cnt  <= max_cntr;
        r_mode <= mode_sat;
      end
      if (r_state == DONE) begin
        r_sat   <= w_result[DW];
        r_s_out <= w_result[DW-1:0];
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign aerr       = r_aerr;
  assign berr       = r_berr;
  assign a_out      = r_a_out;
  assign b_out      = r_b_out;
  assign a_ov       = r_a_ov;
  assign b_ov       = r_b_ov;
  assign start_next = r_start_next;
  assign s_out      = r_s_out;
  assign se         = r_se;
  assign sat        = r_sat;
endmodule

// File: tb/tb_pe_mac_param.sv
// Scoreboard bench for pe_mac_param: expected results and forwarded operands are
// queued as operations are driven and compared against what the monitor records.

module tb_pe_mac_param;
  localparam int DW    = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             mode_sat = 1'b0;
  logic             awe = 1'b0;
  logic             bwe = 1'b0;
  logic [CNT_W-1:0] max_cntr = '0;
  logic [DW-1:0]    a_in = '0;
  logic [DW-1:0]    b_in = '0;
  logic             aff, bff, aerr, berr, a_ov, b_ov, start_next, busy, se, sat;
  logic [DW-1:0]    a_out, b_out, s_out;

  int n_vec  = 0;
  int n_fail = 0;
  int va [4];
  int vb [4];

  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  logic [DW:0]   exp_r [$];
  logic [DW-1:0] obs_a [$];
  logic [DW-1:0] obs_b [$];
  logic [DW-1:0] obs_s [$];
  logic          obs_sat [$];

  always #5 clk = ~clk;

  pe_mac_param #(.DW(DW), .ACC_W(40), .FDEPTH(4), .CNT_W(CNT_W), .FRAC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cntr(max_cntr), .mode_sat(mode_sat),
    .a_in(a_in), .awe(awe), .b_in(b_in), .bwe(bwe), .aff(aff), .bff(bff),
    .aerr(aerr), .berr(berr), .a_out(a_out), .a_ov(a_ov), .b_out(b_out), .b_ov(b_ov),
    .start_next(start_next), .busy(busy), .s_out(s_out), .se(se), .sat(sat)
  );

  always @(negedge clk) begin
    if (a_ov) obs_a.push_back(a_out);
    if (b_ov) obs_b.push_back(b_out);
    if (se) begin
      obs_s.push_back(s_out);
      obs_sat.push_back(sat);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_a.delete(); exp_b.delete(); exp_r.delete();
    obs_a.delete(); obs_b.delete(); obs_s.delete(); obs_sat.delete();
  endtask

  task automatic do_start(int mc, bit ms);
    start    = 1'b1;
    max_cntr = CNT_W'(mc);
    mode_sat = ms;
    tick();
    start    = 1'b0;
  endtask

  task automatic feed(int n);
    for (int i = 0; i < n; i++) begin
      awe = 1'b1; a_in = DW'(va[i]); tick(); awe = 1'b0;
      bwe = 1'b1; b_in = DW'(vb[i]); tick(); bwe = 1'b0;
    end
  endtask

  task automatic sb_push(int n, bit ms);
    longint acc;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      acc += longint'(va[i]) * longint'(vb[i]);
      exp_a.push_back(DW'(va[i]));
      exp_b.push_back(DW'(vb[i]));
    end
    if (ms && acc > 32767)       exp_r.push_back({1'b1, 16'h7fff});
    else if (ms && acc < -32768) exp_r.push_back({1'b1, 16'h8000});
    else                         exp_r.push_back({1'b0, acc[15:0]});
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (obs_s.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({aff, bff, aerr, berr, a_ov, b_ov, start_next, busy, se, sat, a_out, b_out, s_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got a_out=%h b_out=%h s_out=%h busy=%b se=%b aff=%b, required all 0",
               a_out, b_out, s_out, busy, se, aff);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic(string tag);
    bit ok;
    logic [DW:0] er, got;
    va = '{1, 2, 3, 4};
    vb = '{5, 6, 7, 8};
    do_start(4, 1'b1);
    n_vec++;
    if ({start_next, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s_start_next: got start_next=%b busy=%b, required 1 1", tag, start_next, busy);
    end
    sb_push(4, 1'b1);
    feed(4);
    wait_out(ok);
    er = exp_r.pop_front();
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_result: no se within budget, required s_out=%0d", tag, $signed(er[15:0]));
    end else begin
      got = {obs_sat.pop_front(), obs_s.pop_front()};
      if (got !== er) begin
        n_fail++;
        $display("FAIL %s_result: got sat=%b s_out=%0d, required sat=%b s_out=%0d",
                 tag, got[16], $signed(got[15:0]), er[16], $signed(er[15:0]));
      end
    end
    n_vec++;
    if (obs_a.size() != 4 || obs_b.size() != 4) begin
      n_fail++;
      $display("FAIL %s_fwd_count: got a=%0d b=%0d pulses, required 4 4", tag, obs_a.size(), obs_b.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL %s_fwd[%0d]: got a_out=%0d b_out=%0d, required %0d %0d",
                   tag, i, obs_a[i], obs_b[i], exp_a[i], exp_b[i]);
        end
      end
    end
    repeat (3) tick();
    n_vec++;
    if (obs_s.size() != 0) begin
      n_fail++;
      $display("FAIL %s_se_once: got %0d extra se pulses, required 0", tag, obs_s.size());
    end
    clear_q();
  endtask

  task automatic test_saturate();
    bit ok, hit;
    logic [DW:0] er, got;
    va = '{32767, 32767, 32767, 32767};
    vb = '{32767, 32767, 32767, 32767};
    do_start(4, 1'b1);
    sb_push(4, 1'b1);
    feed(4);
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (se) begin
        hit = 1'b1;
        break;
      end
    end
    // start issued in the same cycle that se is high
    do_start(4, 1'b0);
    n_vec++;
    if (!hit || start_next !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_start_on_se: got se_seen=%b start_next=%b, required 1 1", hit, start_next);
    end
    sb_push(4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) feed(4);
      wait_out(ok);
      er = exp_r.pop_front();
      n_vec++;
      if (!ok) begin
        n_fail++;
        $display("FAIL sat_max_result%0d: no se within budget, required s_out=%h", k, er[15:0]);
      end else begin
        got = {obs_sat.pop_front(), obs_s.pop_front()};
        if (got !== er) begin
          n_fail++;
          $display("FAIL sat_max_result%0d: got sat=%b s_out=%h, required sat=%b s_out=%h",
                   k, got[16], got[15:0], er[16], er[15:0]);
        end
      end
    end
    clear_q();
  endtask

  task automatic test_neg_sat();
    bit ok;
    logic [DW:0] er, got;
    va = '{-32768, -32768, 0, 0};
    vb = '{32767, 32767, 0, 0};
    do_start(2, 1'b1);
    sb_push(2, 1'b1);
    feed(2);
    wait_out(ok);
    er = exp_r.pop_front();
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sat_min_result: no se within budget, required s_out=%h", er[15:0]);
    end else begin
      got = {obs_sat.pop_front(), obs_s.pop_front()};
      if (got !== er) begin
        n_fail++;
        $display("FAIL sat_min_result: got sat=%b s_out=%h, required sat=%b s_out=%h",
                 got[16], got[15:0], er[16], er[15:0]);
      end
    end
    clear_q();
  endtask

  task automatic test_fifo_full();
    bit ok;
    logic [DW:0] er, got;
    for (int i = 0; i < 5; i++) begin
      awe = 1'b1; a_in = DW'(10 + i); tick(); awe = 1'b0;
      if (i == 3) begin
        n_vec++;
        if ({aff, aerr} !== 2'b10) begin
          n_fail++;
          $display("FAIL fifo_full_flag: got aff=%b aerr=%b, required 1 0", aff, aerr);
        end
      end
    end
    n_vec++;
    if (aerr !== 1'b1) begin
      n_fail++;
      $display("FAIL fifo_overflow_err: got aerr=%b, required 1", aerr);
    end
    va = '{10, 11, 12, 13};
    vb = '{1, 1, 1, 1};
    do_start(4, 1'b1);
    n_vec++;
    if (aerr !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_err_clear: got aerr=%b, required 0", aerr);
    end
    sb_push(4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bwe = 1'b1; b_in = 16'd1; tick(); bwe = 1'b0;
    end
    wait_out(ok);
    er = exp_r.pop_front();
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fifo_result: no se within budget, required s_out=%0d", er[15:0]);
    end else begin
      got = {obs_sat.pop_front(), obs_s.pop_front()};
      if (got !== er) begin
        n_fail++;
        $display("FAIL fifo_result: got sat=%b s_out=%0d, required sat=%b s_out=%0d",
                 got[16], $signed(got[15:0]), er[16], $signed(er[15:0]));
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= obs_a.size() || obs_a[i] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL fifo_fwd_a[%0d]: got %0d, required %0d", i,
                 (i < obs_a.size()) ? obs_a[i] : 16'hxxxx, exp_a[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_zero_count();
    bit ok;
    logic [DW:0] er, got;
    va = '{0, 0, 0, 0};
    vb = '{0, 0, 0, 0};
    do_start(0, 1'b1);
    sb_push(0, 1'b1);
    n_vec++;
    if ({start_next, se} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_cnt_start_next: got start_next=%b se=%b, required 1 0", start_next, se);
    end
    tick();
    n_vec++;
    if ({se, s_out} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL zero_cnt_se_timing: got se=%b s_out=%h two cycles after start, required 1 0000", se, s_out);
    end
    wait_out(ok);
    er = exp_r.pop_front();
    n_vec++;
    got = ok ? {obs_sat.pop_front(), obs_s.pop_front()} : '1;
    if (!ok || got !== er || obs_a.size() != 0) begin
      n_fail++;
      $display("FAIL zero_cnt_result: got se_seen=%b sat/s_out=%h pops=%0d, required 1 %h 0",
               ok, got, obs_a.size(), er);
    end
    clear_q();
    va = '{3, 4, 0, 0};
    vb = '{2, 2, 0, 0};
    do_start(2, 1'b1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if ({start_next, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got start_next=%b busy=%b, required 0 1", start_next, busy);
    end
    sb_push(2, 1'b1);
    feed(2);
    wait_out(ok);
    er = exp_r.pop_front();
    n_vec++;
    got = ok ? {obs_sat.pop_front(), obs_s.pop_front()} : '1;
    if (!ok || got !== er) begin
      n_fail++;
      $display("FAIL busy_run_result: got se_seen=%b sat/s_out=%h, required 1 %h", ok, got, er);
    end
    clear_q();
  endtask

  task automatic test_async_reset();
    do_start(4, 1'b1);
    awe = 1'b1; bwe = 1'b1;
    a_in = 16'd1; b_in = 16'd5; tick();
    a_in = 16'd2; b_in = 16'd6; tick();
    bwe = 1'b0;
    a_in = 16'd3; tick();
    a_in = 16'd4; tick();
    awe = 1'b0;
    n_vec++;
    if (obs_a.size() != 2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre_pops: got pops=%0d busy=%b, required 2 1", obs_a.size(), busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({aff, bff, aerr, berr, a_ov, b_ov, start_next, busy, se, sat, a_out, b_out, s_out} !== '0) begin
      n_fail++;
      $display("FAIL areset_outputs: got a_out=%h b_out=%h busy=%b a_ov=%b, required all 0",
               a_out, b_out, busy, a_ov);
    end
    #2 rst_n = 1'b1;
    clear_q();
    tick();
    test_basic("rerun");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_saturate();
    test_neg_sat();
    test_fifo_full();
    test_zero_count();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
